tree_loader: RTL and testbench

- Writer side of the treeval node/config sideband: takes packed 32-bit node words from an upstream valid/ready stream and drives the per-field write strobes (mem_weight/mem_par/mem_rew/mem_act) plus the node-count config write (conf_nodes).
- Sits between the host/DMA buffer and treeval, replacing testbench-driven sideband pokes.
- One load = one header word, then N node words in ascending address order, then one config write.

---
 rtl/tree_loader.sv | 217 +++++++++++++++++++++
 tb/tb_tree_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_loader.sv
`default_nettype none
// tree_loader: turns a header + packed node-word stream into per-field treeval writes, then a node-count config write.
// Optional build macro TREE_LOADER_CHECK_EN adds parent-pointer checking (node_err / err_addr ports).
module tree_loader #(
  parameter int NODE_SIZE        = 32,
  parameter int W_ADDR           = 10,
  parameter int W_ACTION         = 3,
  parameter int W_REWARD         = 12,
  parameter int W_WEIGHT         = 7,
  parameter int MAX_DATA_WIDTH   = 12,
  parameter int MAX_CONFIG_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [NODE_SIZE-1:0]        s_data,
  input  logic                        abort,
  output logic                        mem_weight,
  output logic                        mem_par,
  output logic                        mem_rew,
  output logic                        mem_act,
  output logic [W_ADDR-1:0]           mem_addr,
  output logic [MAX_DATA_WIDTH-1:0]   mem_data,
  output logic                        conf_nodes,
  output logic [MAX_CONFIG_WIDTH-1:0] conf_data,
  output logic                        busy,
  output logic                        load_done,
  output logic                        hdr_err
`ifdef TREE_LOADER_CHECK_EN
  ,
  output logic                        node_err,
  output logic [W_ADDR-1:0]           err_addr
`endif
);

  localparam int REW_LSB = W_WEIGHT;
  localparam int ACT_LSB = REW_LSB + W_REWARD;
  localparam int PAR_LSB = ACT_LSB + W_ACTION;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RECV = 3'd1;
  localparam logic [2:0] S_EMIT = 3'd2;
  localparam logic [2:0] S_CONF = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [W_ADDR:0]   MIN_CNT = 2;
  localparam logic [W_ADDR-1:0] ONE_A   = 1;

  logic [2:0]                  state_q, state_d;
  logic [1:0]                  f_q, f_d;
  logic [W_ADDR-1:0]           idx_q, idx_d;
  logic [W_ADDR-1:0]           count_q, count_d;
  logic [NODE_SIZE-1:0]        node_q, node_d;
  logic                        hdr_err_q, hdr_err_d;
  logic [3:0]                  strb_q, strb_d;   // {act, rew, par, weight}
  logic [W_ADDR-1:0]           mem_addr_q, mem_addr_d;
  logic [MAX_DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                        conf_nodes_q, conf_nodes_d;
  logic [MAX_CONFIG_WIDTH-1:0] conf_data_q, conf_data_d;
  logic                        load_done_q, load_done_d;
  logic [W_ADDR:0]             hdr_cnt;
  logic                        hs;

`ifdef TREE_LOADER_CHECK_EN
  logic                        node_err_q, node_err_d;
  logic [W_ADDR-1:0]           err_addr_q, err_addr_d;
  logic [NODE_SIZE-PAR_LSB-1:0] par_w;
  logic                        bad_w;
`endif

  function automatic logic [MAX_DATA_WIDTH-1:0] field(input logic [NODE_SIZE-1:0] w,
                                                      input logic [1:0] f);
    case (f)
      2'd0:    return MAX_DATA_WIDTH'(w[W_WEIGHT-1:0]);
      2'd1:    return MAX_DATA_WIDTH'(w[NODE_SIZE-1:PAR_LSB]);
      2'd2:    return MAX_DATA_WIDTH'(w[ACT_LSB-1:REW_LSB]);
      default: return MAX_DATA_WIDTH'(w[PAR_LSB-1:ACT_LSB]);
    endcase
  endfunction

  assign s_ready = (state_q == S_IDLE) || (state_q == S_RECV);
  assign busy    = (state_q != S_IDLE);
  assign hs      = s_valid && s_ready;
  assign hdr_cnt = s_data[W_ADDR:0];

  always_comb begin
    state_d      = state_q;
    f_d          = f_q;
    idx_d        = idx_q;
    count_d      = count_q;
    node_d       = node_q;
    hdr_err_d    = hdr_err_q;
    strb_d       = 4'b0000;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    conf_nodes_d = 1'b0;
    conf_data_d  = conf_data_q;
    load_done_d  = 1'b0;
`ifdef TREE_LOADER_CHECK_EN
    node_err_d   = node_err_q;
    err_addr_d   = err_addr_q;
    par_w        = s_data[NODE_SIZE-1:PAR_LSB];
    bad_w        = (idx_q == '0) ? (par_w != '1) : (par_w >= idx_q);
`endif
    // Abort wins over everything outside IDLE, including a same-cycle handshake.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (hs) begin
          if (hdr_cnt >= MIN_CNT && !hdr_cnt[W_ADDR]) begin
            count_d   = hdr_cnt[W_ADDR-1:0];
            idx_d     = '0;
            hdr_err_d = 1'b0;
            state_d   = S_RECV;
`ifdef TREE_LOADER_CHECK_EN
            node_err_d = 1'b0;
`endif
          end else begin
            hdr_err_d = 1'b1;
          end
        end
        S_RECV: if (hs) begin
          node_d     = s_data;
          f_d        = 2'd0;
          state_d    = S_EMIT;
          strb_d     = 4'b0001;
          mem_addr_d = idx_q;
          mem_data_d = field(s_data, 2'd0);
`ifdef TREE_LOADER_CHECK_EN
          if (bad_w && !node_err_q) begin
            node_err_d = 1'b1;
            err_addr_d = idx_q;
          end
`endif
        end
        S_EMIT: begin
          if (f_q == 2'd3) begin
            idx_d = idx_q + ONE_A;
            if (idx_q == count_q - ONE_A) begin
              state_d      = S_CONF;
              conf_nodes_d = 1'b1;
              conf_data_d  = MAX_CONFIG_WIDTH'(count_q);
            end else begin
              state_d = S_RECV;
            end
          end else begin
            f_d        = f_q + 2'd1;
            strb_d     = 4'b0001 << f_d;
            mem_data_d = field(node_q, f_d);
          end
        end
        S_CONF: begin
          state_d     = S_DONE;
          load_done_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      f_q          <= 2'd0;
      idx_q        <= '0;
      count_q      <= '0;
      node_q       <= '0;
      hdr_err_q    <= 1'b0;
      strb_q       <= 4'b0000;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      conf_nodes_q <= 1'b0;
      conf_data_q  <= '0;
      load_done_q  <= 1'b0;
`ifdef TREE_LOADER_CHECK_EN
      node_err_q   <= 1'b0;
      err_addr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      f_q          <= f_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      node_q       <= node_d;
      hdr_err_q    <= hdr_err_d;
      strb_q       <= strb_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      conf_nodes_q <= conf_nodes_d;
      conf_data_q  <= conf_data_d;
      load_done_q  <= load_done_d;
`ifdef TREE_LOADER_CHECK_EN
      node_err_q   <= node_err_d;
      err_addr_q   <= err_addr_d;
`endif
    end
  end

  assign mem_weight = strb_q[0];
  assign mem_par    = strb_q[1];
  assign mem_rew    = strb_q[2];
  assign mem_act    = strb_q[3];
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign conf_nodes = conf_nodes_q;
  assign conf_data  = conf_data_q;
  assign load_done  = load_done_q;
  assign hdr_err    = hdr_err_q;
`ifdef TREE_LOADER_CHECK_EN
  assign node_err   = node_err_q;
  assign err_addr   = err_addr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tree_loader.sv
`default_nettype none
// tb_tree_loader: randomized + directed loads checked against an event-list reference model.
module tb_tree_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        abort = 1'b0;
  logic        mem_weight, mem_par, mem_rew, mem_act;
  logic [9:0]  mem_addr;
  logic [11:0] mem_data;
  logic        conf_nodes;
  logic [9:0]  conf_data;
  logic        busy, load_done, hdr_err;
`ifdef TREE_LOADER_CHECK_EN
  logic        node_err;
  logic [9:0]  err_addr;
  logic        exp_err = 1'b0;
  logic [9:0]  exp_err_addr = '0;
`endif

  tree_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .abort(abort), .mem_weight(mem_weight), .mem_par(mem_par), .mem_rew(mem_rew),
    .mem_act(mem_act), .mem_addr(mem_addr), .mem_data(mem_data), .conf_nodes(conf_nodes),
    .conf_data(conf_data), .busy(busy), .load_done(load_done), .hdr_err(hdr_err)
`ifdef TREE_LOADER_CHECK_EN
    , .node_err(node_err), .err_addr(err_addr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cyc = 0;
  int hdr_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] nodes[0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Event encoding: kind 0..3 = weight/parent/reward/action write, 4 = config, 5 = load_done.
  function automatic logic [31:0] ev(input int kind, input int addr, input int data);
    return {4'(kind), 6'd0, 10'(addr), 12'(data)};
  endfunction

  function automatic logic [31:0] mk(input int par, input int act, input int rew, input int w);
    return {10'(par), 3'(act), 12'(rew), 7'(w)};
  endfunction

  // Reference: node word split by plain arithmetic into fields, emitted in W,P,R,A order.
  task automatic push_node(input int k, input logic [31:0] word, input int nf);
    longint unsigned w;
    int vals[4];
    w = word;
    vals[0] = int'(w % 128);
    vals[1] = int'(w / (64'd1 << 22));
    vals[2] = int'((w / 128) % 4096);
    vals[3] = int'((w / (64'd1 << 19)) % 8);
    for (int f = 0; f < nf; f++) exp_q.push_back(ev(f, k, vals[f]));
  endtask

  always @(negedge clk) begin : monitor
    int n;
    int kind;
    logic [31:0] obs;
    if (rst_n) begin
      n = int'(mem_weight) + int'(mem_par) + int'(mem_rew) + int'(mem_act)
        + int'(conf_nodes) + int'(load_done);
      if (n > 1) check("onehot", n, 1);
      if (n != 0) begin
        kind = mem_weight ? 0 : mem_par ? 1 : mem_rew ? 2 : mem_act ? 3 : conf_nodes ? 4 : 5;
        if (kind < 4)       obs = ev(kind, int'(mem_addr), int'(mem_data));
        else if (kind == 4) obs = ev(4, 0, int'(conf_data));
        else                obs = ev(5, 0, 0);
        if (load_done) done_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_event", obs, 32'hFFFF_FFFF);
        else check("event", obs, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [31:0] w, input bit ab);
    bit got;
    got = 1'b0;
    s_valid = 1'b1; s_data = w; abort = ab;
    for (int i = 0; i < 100 && !got; i++) begin
      if (s_ready) got = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0; abort = 1'b0;
    if (!got) check("handshake_timeout", 0, 1);
  endtask

  function automatic logic [31:0] hdr(input int cnt);
    logic [31:0] r;
    r = $urandom();
    return (r & ~32'h7FF) | 32'(cnt);
  endfunction

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; abort = 1'b0;
    exp_q.delete();
`ifdef TREE_LOADER_CHECK_EN
    exp_err = 1'b0; exp_err_addr = '0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_load(input int cnt, input int gap_max, input bit ab_hdr);
    longint unsigned par;
    for (int k = 0; k < cnt; k++) push_node(k, nodes[k], 4);
    exp_q.push_back(ev(4, 0, cnt));
    exp_q.push_back(ev(5, 0, 0));
`ifdef TREE_LOADER_CHECK_EN
    exp_err = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      par = longint'(nodes[k]) / (64'd1 << 22);
      if (!exp_err && ((k == 0) ? (par != 1023) : (par >= longint'(k)))) begin
        exp_err = 1'b1; exp_err_addr = 10'(k);
      end
    end
`endif
    send(hdr(cnt), ab_hdr);
    hdr_cyc = cyc;
    check("hdr_err_cleared", hdr_err, 0);
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send(nodes[k], 1'b0);
    end
    wait_idle();
    check("queue_drained", exp_q.size(), 0);
`ifdef TREE_LOADER_CHECK_EN
    check("node_err", node_err, exp_err);
    check("err_addr", err_addr, exp_err_addr);
`endif
  endtask

  task automatic rand_nodes(input int cnt);
    int p;
    for (int k = 0; k < cnt; k++) begin
      if ($urandom_range(0, 1) == 0) p = (k == 0) ? 1023 : $urandom_range(0, k - 1);
      else p = $urandom_range(0, 1023);
      nodes[k] = mk(p, $urandom_range(0, 7), $urandom_range(0, 4095), $urandom_range(0, 127));
    end
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs",
          {mem_weight, mem_par, mem_rew, mem_act, conf_nodes, load_done, busy, s_ready, hdr_err},
          9'b000000010);
    check("reset_addr_data", {mem_addr, mem_data, conf_data}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-node load with s_valid held high, including a negative reward.
    nodes[0] = mk(10'h3FF, 0, 0, 0);
    nodes[1] = mk(0, 1, 100, 64);
    nodes[2] = mk(0, 2, 12'hFFB, 64);
    run_load(3, 0, 1'b0);
    check("latency_hdr_to_done", done_cyc - hdr_cyc, 16);
    check("conf_data_after_load", conf_data, 3);

    // Illegal headers, then a legal one clears the sticky flag.
    send(hdr(1), 1'b0);
    check("hdr_err_cnt1", {hdr_err, busy}, 2'b10);
    send(hdr(1024), 1'b0);
    check("hdr_err_cnt1024", {hdr_err, busy, s_ready}, 3'b101);
    rand_nodes(2);
    run_load(2, 1, 1'b0);

    // Seven-cycle s_valid gap between nodes 1 and 2.
    rand_nodes(3);
    for (int k = 0; k < 3; k++) push_node(k, nodes[k], 4);
    exp_q.push_back(ev(4, 0, 3));
    exp_q.push_back(ev(5, 0, 0));
    send(hdr(3), 1'b0);
    send(nodes[0], 1'b0);
    send(nodes[1], 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      check("gap_ready_no_strobe",
            {s_ready, mem_weight, mem_par, mem_rew, mem_act, conf_nodes}, 6'b100000);
      @(negedge clk);
    end
    send(nodes[2], 1'b0);
    check("gap_resume_weight", {mem_weight, mem_addr}, {1'b1, 10'd2});
    wait_idle();
    check("gap_drained", exp_q.size(), 0);

    // Abort during the reward write of node 1.
    rand_nodes(4);
    push_node(0, nodes[0], 4);
    push_node(1, nodes[1], 3);
    send(hdr(4), 1'b0);
    send(nodes[0], 1'b0);
    send(nodes[1], 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_at_reward", {mem_rew, mem_addr}, {1'b1, 10'd1});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {busy, s_ready, conf_nodes, load_done}, 4'b0100);
    repeat (3) @(negedge clk);
    check("abort_drained", exp_q.size(), 0);

    // Asynchronous reset while the parent write of node 1 is on the bus.
    rand_nodes(3);
    push_node(0, nodes[0], 4);
    push_node(1, nodes[1], 2);
    send(hdr(3), 1'b0);
    send(nodes[0], 1'b0);
    send(nodes[1], 1'b0);
    @(negedge clk);
    check("pre_reset_par", mem_par, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {mem_weight, mem_par, mem_rew, mem_act, conf_nodes, load_done, busy, s_ready, hdr_err},
          9'b000000010);
    check("async_reset_addr_data", {mem_addr, mem_data, conf_data}, 32'h0);
    check("reset_drained", exp_q.size(), 0);
    do_reset();

`ifdef TREE_LOADER_CHECK_EN
    nodes[0] = mk(10'h3FF, 1, 5, 3);
    nodes[1] = mk(0, 2, 6, 4);
    nodes[2] = mk(5, 3, 7, 5);
    run_load(3, 0, 1'b0);
    check("chk_node_err_set", {node_err, err_addr}, {1'b1, 10'd2});
`endif

    // Randomized loads with occasional illegal headers and IDLE-time aborts.
    for (int t = 0; t < 15; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       send(hdr(0), 1'b0);
          1:       send(hdr(1), 1'b0);
          default: send(hdr(1024 + $urandom_range(0, 1023)), 1'b0);
        endcase
        check("rand_hdr_err", {hdr_err, busy}, 2'b10);
      end
      cnt = $urandom_range(2, 6);
      rand_nodes(cnt);
      run_load(cnt, 2, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
